// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: carries decoder controls ID->EX->MEM->WB, stalls on RAW hazards.
// Optional macro FWD_EN: load-use-only stalls plus MEM/WB forward selects.

module ctrl_pipe_hazard #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_reg_dst,
    input  logic                  id_branch,
    input  logic                  id_mem_read,
    input  logic                  id_mem_to_reg,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic                  id_mem_write,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic                  ex_alu_src,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  mem_valid,
    output logic                  mem_branch,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    typedef logic [REG_ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_to_reg;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        addr_t               rs;
        addr_t               rt;
        addr_t               dest;
    } ex_t;

    typedef struct packed {
        logic  valid;
        logic  reg_write;
        logic  mem_to_reg;
        logic  branch;
        logic  mem_read;
        logic  mem_write;
        addr_t dest;
    } mem_t;

    typedef struct packed {
        logic  valid;
        logic  reg_write;
        logic  mem_to_reg;
        addr_t dest;
    } wb_t;

    ex_t  ex_q;
    ex_t  ex_d;
    ex_t  id_cap;
    mem_t mem_q;
    mem_t mem_d;
    mem_t ex2mem;
    wb_t  wb_q;
    wb_t  wb_d;

    logic rt_used;
    logic ex_hit;
    logic raw;

    // Register 0 is hardwired, so it can never carry a dependency.
    function automatic logic hit(
        input logic  v,
        input logic  rw,
        input addr_t dest,
        input addr_t src
    );
        return v & rw & (src != '0) & (dest == src);
    endfunction

    // Decoder don't-cares are squashed here so nothing unknown is registered.
    always_comb begin
        id_cap = '0;
        if (id_valid) begin
            id_cap.valid      = 1'b1;
            id_cap.reg_write  = id_reg_write;
            id_cap.mem_to_reg = id_reg_write & id_mem_to_reg;
            id_cap.branch     = id_branch;
            id_cap.mem_read   = id_mem_read;
            id_cap.mem_write  = id_mem_write;
            id_cap.alu_op     = id_alu_op;
            id_cap.alu_src    = id_alu_src;
            id_cap.rs         = id_rs;
            id_cap.rt         = id_rt;
            if (id_reg_write) begin
                id_cap.dest = id_reg_dst ? id_rd : id_rt;
            end
        end
    end

    always_comb begin
        ex2mem            = '0;
        ex2mem.valid      = ex_q.valid;
        ex2mem.reg_write  = ex_q.reg_write;
        ex2mem.mem_to_reg = ex_q.mem_to_reg;
        ex2mem.branch     = ex_q.branch;
        ex2mem.mem_read   = ex_q.mem_read;
        ex2mem.mem_write  = ex_q.mem_write;
        ex2mem.dest       = ex_q.dest;
    end

    assign rt_used = ~id_alu_src | id_mem_write | id_branch;

    assign ex_hit =
        hit(ex_q.valid, ex_q.reg_write, ex_q.dest, id_rs) |
        (rt_used & hit(ex_q.valid, ex_q.reg_write, ex_q.dest, id_rt));

`ifdef FWD_EN
    assign raw = ex_q.mem_read & ex_hit;

    // MEM result is newer than WB, so it wins.
    always_comb begin
        fwd_a = 2'b00;
        if (hit(mem_q.valid, mem_q.reg_write, mem_q.dest, ex_q.rs)) begin
            fwd_a = 2'b10;
        end else if (hit(wb_q.valid, wb_q.reg_write, wb_q.dest, ex_q.rs)) begin
            fwd_a = 2'b01;
        end
    end

    always_comb begin
        fwd_b = 2'b00;
        if (hit(mem_q.valid, mem_q.reg_write, mem_q.dest, ex_q.rt)) begin
            fwd_b = 2'b10;
        end else if (hit(wb_q.valid, wb_q.reg_write, wb_q.dest, ex_q.rt)) begin
            fwd_b = 2'b01;
        end
    end
`else
    logic mem_hit;

    assign mem_hit =
        hit(mem_q.valid, mem_q.reg_write, mem_q.dest, id_rs) |
        (rt_used & hit(mem_q.valid, mem_q.reg_write, mem_q.dest, id_rt));

    assign raw   = ex_hit | mem_hit;
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign stall = id_valid & ~flush & raw;

    always_comb begin
        ex_d            = '0;
        mem_d           = '0;
        wb_d            = '0;
        wb_d.valid      = mem_q.valid;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.mem_to_reg = mem_q.mem_to_reg;
        wb_d.dest       = mem_q.dest;
        unique case (1'b1)
            flush: begin
                mem_d = '0;
            end
            stall: begin
                mem_d = ex2mem;
            end
            default: begin
                ex_d  = id_cap;
                mem_d = ex2mem;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign mem_valid     = mem_q.valid;
    assign mem_branch    = mem_q.branch;
    assign mem_read      = mem_q.mem_read;
    assign mem_write     = mem_q.mem_write;
    assign wb_valid      = wb_q.valid;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_write_reg  = wb_q.dest;

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Receiving end of the main decoder's control bundle (reg_dst, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write).
- Registers the bundle from ID through the EX, MEM and WB pipeline stages.
- Detects RAW hazards against in-flight instructions and drives a stall to the fetch/ID stage.
- Inserts bubbles on stall and on branch flush, so downstream datapath blocks see clean, X-free controls.

Parameters:
REG_ADDR_W, 5, register-file address width
ALU_OP_W, 2, width of the alu_op field

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_reg_dst  input  1  decoder reg_dst (may be X)
id_branch  input  1  decoder branch
id_mem_read  input  1  decoder mem_read
id_mem_to_reg  input  1  decoder mem_to_reg (may be X)
id_alu_op  input  ALU_OP_W  decoder alu_op
id_mem_write  input  1  decoder mem_write
id_alu_src  input  1  decoder alu_src
id_reg_write  input  1  decoder reg_write
id_rs  input  REG_ADDR_W  source register rs
id_rt  input  REG_ADDR_W  source/dest register rt
id_rd  input  REG_ADDR_W  dest register rd
flush  input  1  branch taken, resolved in MEM
stall  output  1  hold PC and IF/ID this cycle (combinational)
ex_valid  output  1  EX stage valid
ex_alu_op  output  ALU_OP_W  EX alu_op
ex_alu_src  output  1  EX alu_src
ex_rs  output  REG_ADDR_W  EX rs
ex_rt  output  REG_ADDR_W  EX rt
mem_valid  output  1  MEM stage valid
mem_branch  output  1  MEM branch
mem_read  output  1  MEM mem_read
mem_write  output  1  MEM mem_write
wb_valid  output  1  WB stage valid
wb_reg_write  output  1  WB reg_write
wb_mem_to_reg  output  1  WB mem_to_reg
wb_write_reg  output  REG_ADDR_W  WB destination register
fwd_a  output  2  ALU operand A forward select
fwd_b  output  2  ALU operand B forward select

Behaviour:
- Reset (rst_n=0, async): every stage invalid. Every registered output is 0, including addresses. stall, fwd_a and fwd_b are 0.
- Sanitising on ID capture:
  - If id_valid=0, every captured control is 0.
  - If reg_write=0, mem_to_reg is forced to 0 and the destination is forced to 0.
  - The EX destination is resolved as reg_dst ? rd : rt, then carried to MEM and WB.
  - No X is ever registered.
- ID source usage:
  - rs is always used.
  - rt is used iff (alu_src=0) or mem_write or branch.
- Each rising edge, priority order:
  - flush=1: EX←bubble, MEM←bubble, WB←MEM. Flush wins over stall.
  - else stall=1: EX←bubble, MEM←EX, WB←MEM. IF/ID is held externally.
  - else: EX←ID (sanitised), MEM←EX, WB←MEM.
- A bubble is valid=0 with all controls and addresses 0.
- Latency: ID to EX 1 cycle, to MEM 2, to WB 3.
- Hazard matching: register 0 never matches. A stage participates only if valid and reg_write.
- stall, FWD_EN defined (load-use only): asserted when ex_valid, ex_mem_read, and ex_dest equals a used ID source.
- stall, FWD_EN undefined: asserted when a used ID source equals the EX dest or the MEM dest.
- stall is masked to 0 when id_valid=0 or flush=1.
- WB writes during the same cycle are assumed write-first in the register file, so WB is never a hazard.
- Back-to-back stalls are permitted. The held ID instruction re-evaluates each cycle.

Optional Feature:
- Macro: FWD_EN.
- Defined:
  - fwd_a and fwd_b select 2'b10 when the MEM dest matches ex_rs / ex_rt.
  - Otherwise 2'b01 when the WB dest matches.
  - Otherwise 2'b00.
  - MEM takes precedence over WB.
  - Stall is load-use only.
- Undefined:
  - fwd_a and fwd_b are tied to 2'b00.
  - Stall covers all EX and MEM RAW hazards, as in Behaviour.

Test Plan:
- Reset mid-stream: assert rst_n=0 with all stages valid -> all outputs 0 immediately, before the next clk edge.
- R-type (reg_dst=1, rd=5, reg_write=1) then idle -> wb_valid=1, wb_write_reg=5, wb_reg_write=1 exactly 3 cycles later.
- Load rt=8 followed by R-type with rs=8 -> stall=1 for exactly 1 cycle (FWD_EN) or 2 cycles (no FWD_EN); EX holds a bubble; the R-type reaches EX afterwards.
- FWD_EN: R-type dest 3, then R-type rs=3, rt=3 -> fwd_a=fwd_b=2'b10; with one nop between them -> 2'b01.
- Store with X reg_dst/mem_to_reg, and a write to $0 -> no X on any output, no stall, wb_write_reg=0.
- flush=1 coincident with a load-use stall -> stall=0; EX and MEM are bubbles next cycle; the older instruction in MEM proceeds to WB.
